// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
package vga_timing_pkg;

    // Porch/sync sets for the supported modes (pixels for h, lines for v).
    localparam int M640_H_ACTIVE = 640;
    localparam int M640_H_FP     = 16;
    localparam int M640_H_SYNC   = 96;
    localparam int M640_H_BP     = 48;
    localparam int M640_V_ACTIVE = 480;
    localparam int M640_V_FP     = 10;
    localparam int M640_V_SYNC   = 2;
    localparam int M640_V_BP     = 33;

    localparam int M800_H_ACTIVE = 800;
    localparam int M800_H_FP     = 40;
    localparam int M800_H_SYNC   = 128;
    localparam int M800_H_BP     = 88;
    localparam int M800_V_ACTIVE = 600;
    localparam int M800_V_FP     = 1;
    localparam int M800_V_SYNC   = 4;
    localparam int M800_V_BP     = 23;

    // Length of one full axis period: active, front porch, sync, back porch.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag, plus decodes of the position
// the counter will hold after this cycle, so the top can register them in step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int WIN0   = 0,
    parameter int WINW   = 640,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] pos,
    output logic          wrap,
    output logic          active_next,
    output logic          sync_next,
    output logic          win_next,
    output logic [CW-1:0] rel_next
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_W  = CW'(SYNC);
    localparam logic [CW-1:0] WIN_LO  = CW'(WIN0);
    localparam logic [CW-1:0] WIN_W   = CW'(WINW);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_interval
        $error("vga_axis_counter: active, porch and sync intervals must all be non-zero");
    end
    if (WIN0 < 0 || WINW < 0 || WIN0 + WINW > ACTIVE) begin : g_bad_window
        $error("vga_axis_counter: window must lie inside the active region");
    end
    if (CW < 2 || CW > 30 || TOTAL >= (1 << CW)) begin : g_bad_width
        $error("vga_axis_counter: axis total does not fit in CW bits");
    end

    logic [CW-1:0] pos_nxt;
    logic [CW-1:0] sync_off;

    assign wrap    = (pos == LAST);
    assign pos_nxt = step ? (wrap ? '0 : pos + CW'(1)) : pos;

    // Offsets below the interval start wrap to large values, so one
    // unsigned compare covers both bounds of each interval.
    assign sync_off    = pos_nxt - SYNC_LO;
    assign rel_next    = win_next ? (pos_nxt - WIN_LO) : '0;
    assign active_next = (pos_nxt < ACT_END);
    assign sync_next   = (sync_off < SYNC_W) ? POL : ~POL;
    assign win_next    = ((pos_nxt - WIN_LO) < WIN_W);

    // Position register; reset parks on the last position so the first step enters 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= LAST;
        end else begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock-enable divider, h/v axis counters,
// registered sync/enable/window outputs aligned with hpos/vpos, and frame count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = M640_H_ACTIVE,
    parameter int H_FP     = M640_H_FP,
    parameter int H_SYNC   = M640_H_SYNC,
    parameter int H_BP     = M640_H_BP,
    parameter int V_ACTIVE = M640_V_ACTIVE,
    parameter int V_FP     = M640_V_FP,
    parameter int V_SYNC   = M640_V_SYNC,
    parameter int V_BP     = M640_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int WIN_X0   = 0,
    parameter int WIN_W    = 640,
    parameter int WIN_Y0   = 0,
    parameter int WIN_H    = 480,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          win_de,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic [CW-1:0] win_x,
    output logic [CW-1:0] win_y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div;
    logic          h_wrap, v_wrap;
    logic          h_act_n, v_act_n;
    logic          h_sync_n, v_sync_n;
    logic          h_win_n, v_win_n, win_n;
    logic [CW-1:0] h_rel_n, v_rel_n;

    // With CLK_DIV==1 the divider never leaves 0, so pix_ce reduces to en.
    assign pix_ce = en && (div == DIV_LAST);
    assign win_n  = h_win_n & v_win_n;

    // Pixel-rate divider; holds its phase while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + DW'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .WIN0   (WIN_X0),
        .WINW   (WIN_W),
        .CW     (CW)
    ) u_h (
        .clk         (clk),
        .rst         (rst),
        .step        (pix_ce),
        .pos         (hpos),
        .wrap        (h_wrap),
        .active_next (h_act_n),
        .sync_next   (h_sync_n),
        .win_next    (h_win_n),
        .rel_next    (h_rel_n)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .WIN0   (WIN_Y0),
        .WINW   (WIN_H),
        .CW     (CW)
    ) u_v (
        .clk         (clk),
        .rst         (rst),
        .step        (pix_ce & h_wrap),
        .pos         (vpos),
        .wrap        (v_wrap),
        .active_next (v_act_n),
        .sync_next   (v_sync_n),
        .win_next    (v_win_n),
        .rel_next    (v_rel_n)
    );

    // Output registers load the decode of the position being entered, keeping them aligned with hpos/vpos.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            win_de      <= 1'b0;
            win_x       <= '0;
            win_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'hFFFF;
        end else if (pix_ce) begin
            hsync       <= h_sync_n;
            vsync       <= v_sync_n;
            de          <= h_act_n & v_act_n;
            win_de      <= win_n;
            win_x       <= win_n ? h_rel_n : '0;
            win_y       <= win_n ? v_rel_n : '0;
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
            if (h_wrap & v_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny CLK_DIV=1,
// positive-polarity, windowed instance, both compared every clock against a
// model that derives the raster from a count of pixel periods since reset.
module tb_vga_timing_gen;

    localparam int CW = 12;

    typedef struct packed {
        int div;
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int wx0, ww, wy0, wh;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic          pix_ce, hsync, vsync, de, win_de, ls, fs;
        logic [CW-1:0] hpos, vpos, wx, wy;
        logic [15:0]   fc;
    } out_t;

    localparam cfg_t CA = '{div: 4, ha: 640, hf: 16, hs: 96, hb: 48,
                            va: 480, vf: 10, vs: 2, vb: 33,
                            wx0: 0, ww: 640, wy0: 0, wh: 480, hp: 1'b0, vp: 1'b0};
    localparam cfg_t CB = '{div: 1, ha: 8, hf: 2, hs: 3, hb: 2,
                            va: 6, vf: 1, vs: 2, vb: 2,
                            wx0: 2, ww: 3, wy0: 1, wh: 4, hp: 1'b1, vp: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    always #5 clk = ~clk;

    logic          pix_ce_a, hsync_a, vsync_a, de_a, win_de_a, ls_a, fs_a;
    logic [CW-1:0] hpos_a, vpos_a, wx_a, wy_a;
    logic [15:0]   fc_a;
    logic          pix_ce_b, hsync_b, vsync_b, de_b, win_de_b, ls_b, fs_b;
    logic [CW-1:0] hpos_b, vpos_b, wx_b, wy_b;
    logic [15:0]   fc_b;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .en(en_a), .pix_ce(pix_ce_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .win_de(win_de_a),
        .hpos(hpos_a), .vpos(vpos_a), .win_x(wx_a), .win_y(wy_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .H_POL(1'b1), .V_POL(1'b1),
        .WIN_X0(2), .WIN_W(3), .WIN_Y0(1), .WIN_H(4), .CW(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .pix_ce(pix_ce_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .win_de(win_de_b),
        .hpos(hpos_b), .vpos(vpos_b), .win_x(wx_b), .win_y(wy_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int k_a = -1, ph_a = 0, k_b = -1, ph_b = 0;
    int cyc = 0;

    // Expected outputs after k pixel periods have been entered (k<0: still in reset state).
    function automatic out_t model(input cfg_t c, input int k, input logic en, input int ph);
        out_t r;
        int ht, vt, h, v;
        bit inw;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        r = '0;
        r.pix_ce = en && (ph == c.div - 1);
        if (k < 0) begin
            r.hpos  = CW'(ht - 1);
            r.vpos  = CW'(vt - 1);
            r.hsync = ~c.hp;
            r.vsync = ~c.vp;
            r.fc    = 16'hFFFF;
        end else begin
            h = k % ht;
            v = (k / ht) % vt;
            inw = (h >= c.wx0) && (h < c.wx0 + c.ww) && (v >= c.wy0) && (v < c.wy0 + c.wh);
            r.hpos   = CW'(h);
            r.vpos   = CW'(v);
            r.hsync  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
            r.vsync  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
            r.de     = (h < c.ha) && (v < c.va);
            r.win_de = inw;
            r.wx     = inw ? CW'(h - c.wx0) : '0;
            r.wy     = inw ? CW'(v - c.wy0) : '0;
            r.ls     = (h == 0);
            r.fs     = (h == 0) && (v == 0);
            r.fc     = 16'(k / (ht * vt));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp(input string dn, input out_t g, input out_t e);
        chk({dn, ".pix_ce"},      32'(g.pix_ce), 32'(e.pix_ce));
        chk({dn, ".hsync"},       32'(g.hsync),  32'(e.hsync));
        chk({dn, ".vsync"},       32'(g.vsync),  32'(e.vsync));
        chk({dn, ".de"},          32'(g.de),     32'(e.de));
        chk({dn, ".win_de"},      32'(g.win_de), 32'(e.win_de));
        chk({dn, ".line_start"},  32'(g.ls),     32'(e.ls));
        chk({dn, ".frame_start"}, 32'(g.fs),     32'(e.fs));
        chk({dn, ".hpos"},        32'(g.hpos),   32'(e.hpos));
        chk({dn, ".vpos"},        32'(g.vpos),   32'(e.vpos));
        chk({dn, ".win_x"},       32'(g.wx),     32'(e.wx));
        chk({dn, ".win_y"},       32'(g.wy),     32'(e.wy));
        chk({dn, ".frame_cnt"},   32'(g.fc),     32'(e.fc));
    endtask

    task automatic check_all();
        out_t oa, ob;
        oa.pix_ce = pix_ce_a; oa.hsync = hsync_a; oa.vsync = vsync_a; oa.de = de_a;
        oa.win_de = win_de_a; oa.ls = ls_a; oa.fs = fs_a; oa.hpos = hpos_a; oa.vpos = vpos_a;
        oa.wx = wx_a; oa.wy = wy_a; oa.fc = fc_a;
        ob.pix_ce = pix_ce_b; ob.hsync = hsync_b; ob.vsync = vsync_b; ob.de = de_b;
        ob.win_de = win_de_b; ob.ls = ls_b; ob.fs = fs_b; ob.hpos = hpos_b; ob.vpos = vpos_b;
        ob.wx = wx_b; ob.wy = wy_b; ob.fc = fc_b;
        cmp("A", oa, model(CA, k_a, en_a, ph_a));
        cmp("B", ob, model(CB, k_b, en_b, ph_b));
    endtask

    // Advance the model across the coming clock edge with the enables now applied.
    task automatic step_model();
        if (en_a && ph_a == CA.div - 1) k_a++;
        if (en_a) ph_a = (ph_a + 1) % CA.div;
        if (en_b && ph_b == CB.div - 1) k_b++;
        if (en_b) ph_b = (ph_b + 1) % CB.div;
    endtask

    task automatic cycle(input logic ea, input logic eb);
        @(negedge clk);
        en_a = ea;
        en_b = eb;
        #1;
        check_all();
        step_model();
        cyc++;
    endtask

    // Reset pulse placed between clock edges; outputs must already be at reset values.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        k_a = -1; ph_a = 0; k_b = -1; ph_b = 0;
        check_all();
        #1;
        rst = 1'b0;
        step_model();
        cyc++;
    endtask

    function automatic logic rnd_en(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    int   ls_q[$];
    logic ls_prev;

    initial begin
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous run of A over more than two lines; measure line_start spacing.
        ls_prev = 1'b0;
        for (int i = 0; i < 7300; i++) begin
            cycle(1'b1, rnd_en(70));
            if (ls_a && !ls_prev) ls_q.push_back(cyc);
            ls_prev = ls_a;
        end
        chk("line_period_clks", (ls_q.size() >= 2) ? 32'(ls_q[1] - ls_q[0]) : 32'd0, 32'd3200);

        // Freeze A at hpos 100 for 50 clocks, then confirm it resumes at 101.
        for (int i = 0; i < 4000 && hpos_a != CW'(100); i++) cycle(1'b1, rnd_en(70));
        chk("reach_hpos100", 32'(hpos_a), 32'd100);
        for (int i = 0; i < 50; i++) cycle(1'b0, rnd_en(70));
        chk("frozen_hpos", 32'(hpos_a), 32'd100);
        for (int i = 0; i < 8 && hpos_a == CW'(100); i++) cycle(1'b1, rnd_en(70));
        chk("resume_hpos", 32'(hpos_a), 32'd101);

        for (int i = 0; i < 6000; i++) cycle(rnd_en(75), rnd_en(60));

        mid_reset();
        for (int i = 0; i < 2000; i++) cycle(rnd_en(80), rnd_en(80));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
